// File: rtl/full_adder_unit.sv
// One-bit full adder cell: zero-latency combinational sum/carry plus a registered
// copy and a carry loop so the cell can be chained in time as a bit-serial adder.
module full_adder_unit #(
    parameter logic RESET_CARRY = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic en,
    input  logic serial,
    input  logic sclr,
    output logic sum,
    output logic cout,
    output logic sum_q,
    output logic cout_q,
    output logic carry_q
);

    logic c_loop;
    logic c_sel;
    logic sum_sel;
    logic cout_sel;

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

    // A clear starts a new word, so the word's first bit must already see the reset carry.
    assign c_loop   = sclr ? RESET_CARRY : carry_q;
    assign c_sel    = serial ? c_loop : cin;
    assign sum_sel  = a ^ b ^ c_sel;
    assign cout_sel = (a & b) | (a & c_sel) | (b & c_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= 1'b0;
            cout_q  <= 1'b0;
            carry_q <= RESET_CARRY;
        end else if (en) begin
            sum_q  <= sum_sel;
            cout_q <= cout_sel;
            if (sclr) begin
                carry_q <= RESET_CARRY;
            end else if (serial) begin
                carry_q <= cout_sel;
            end else begin
                carry_q <= cout;
            end
        end
    end

endmodule

// File: tb/tb_full_adder_unit.sv
// Directed bench for full_adder_unit: combinational sweep, registered path, hold,
// asynchronous reset and bit-serial word additions.
module tb_full_adder_unit;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic cin;
    logic en;
    logic serial;
    logic sclr;
    logic sum;
    logic cout;
    logic sum_q;
    logic cout_q;
    logic carry_q;

    int checks = 0;
    int errors = 0;

    full_adder_unit #(.RESET_CARRY(1'b0)) dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
        .cin(cin),
        .en(en),
        .serial(serial),
        .sclr(sclr),
        .sum(sum),
        .cout(cout),
        .sum_q(sum_q),
        .cout_q(cout_q),
        .carry_q(carry_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic ia, input logic ib, input logic ic,
                         input logic ien, input logic iser, input logic iclr);
        a = ia; b = ib; cin = ic; en = ien; serial = iser; sclr = iclr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_state();
        #1;
        checks++;
        if ({sum_q, cout_q, carry_q} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state got %b expected 000", {sum_q, cout_q, carry_q});
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_comb();
        logic [1:0] exp_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            drive(v[2], v[1], v[0], 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if ({cout, sum} !== exp_tab[i]) begin
                errors++;
                $display("FAIL comb abc=%b got %b expected %b", v, {cout, sum}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_registered();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if ({sum_q, cout_q, carry_q} !== 3'b011) begin
            errors++;
            $display("FAIL registered got %b expected 011", {sum_q, cout_q, carry_q});
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if ({sum_q, cout_q, carry_q} !== 3'b011) begin
            errors++;
            $display("FAIL registered_cin got %b expected 011", {sum_q, cout_q, carry_q});
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if ({sum_q, cout_q, carry_q} !== 3'b100) begin
            errors++;
            $display("FAIL registered_sum got %b expected 100", {sum_q, cout_q, carry_q});
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_hold();
        logic [2:0] hold_vec [3] = '{3'b000, 3'b101, 3'b111};
        for (int i = 0; i < 3; i++) begin
            drive(hold_vec[i][2], hold_vec[i][1], hold_vec[i][0], 1'b0, i[0], 1'b1);
            tick();
            checks++;
            if ({sum_q, cout_q, carry_q} !== 3'b011) begin
                errors++;
                $display("FAIL hold edge %0d got %b expected 011", i, {sum_q, cout_q, carry_q});
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({sum_q, cout_q, carry_q} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset got %b expected 000", {sum_q, cout_q, carry_q});
        end
        tick();
        checks++;
        if ({sum_q, cout_q, carry_q} !== 3'b000) begin
            errors++;
            $display("FAIL reset_dominates got %b expected 000", {sum_q, cout_q, carry_q});
        end
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if ({sum_q, cout_q, carry_q} !== 3'b011) begin
            errors++;
            $display("FAIL reset_release got %b expected 011", {sum_q, cout_q, carry_q});
        end
    endtask

    task automatic test_serial_add();
        logic [3:0] wa = 4'b0101;
        logic [3:0] wb = 4'b0111;
        logic [3:0] exp_sum = 4'b1100;
        logic [3:0] exp_carry = 4'b0111;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        checks++;
        if (carry_q !== 1'b0) begin
            errors++;
            $display("FAIL serial_add_clear got %b expected 0", carry_q);
        end
        for (int i = 0; i < 4; i++) begin
            drive(wa[i], wb[i], 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
            checks++;
            if ({sum_q, carry_q} !== {exp_sum[i], exp_carry[i]}) begin
                errors++;
                $display("FAIL serial_add bit %0d got %b expected %b", i,
                         {sum_q, carry_q}, {exp_sum[i], exp_carry[i]});
            end
        end
    endtask

    task automatic test_serial_overflow();
        logic [3:0] wa = 4'b1111;
        logic [3:0] wb = 4'b0001;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(wa[i], wb[i], 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
            checks++;
            if ({sum_q, carry_q} !== 2'b01) begin
                errors++;
                $display("FAIL serial_ovf bit %0d got %b expected 01", i, {sum_q, carry_q});
            end
        end
        // Clear with carry_q=1: the cleared carry feeds this bit and the clear wins.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        checks++;
        if ({sum_q, cout_q, carry_q} !== 3'b010) begin
            errors++;
            $display("FAIL serial_clear_wins got %b expected 010", {sum_q, cout_q, carry_q});
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset_state();
        test_comb();
        test_registered();
        test_hold();
        test_async_reset();
        test_serial_add();
        test_serial_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
